crc_stream_framer: RTL and testbench

//  Parametrised streaming CRC engine for the DAQ readout path. GEN mode appends CRC words to each frame.
//  CHK mode passes frames through unchanged and flags a residue mismatch at end of frame.

---
 rtl/crc_pkg.sv | 41 ++++
 rtl/crc_lfsr_step.sv | 29 ++
 rtl/crc_stream_framer.sv | 164 ++++++++++++++++
 tb/tb_crc_stream_framer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared types and bit-level helpers for the streaming CRC framer.
package crc_pkg;

  typedef enum logic {DATA, APPEND} state_t;

  // Widest CRC register the helpers operate on.
  localparam int unsigned MAX_W = 64;

  // One serial LFSR step over the low w bits: shift MSB out, fold POLY in on feedback.
  function automatic logic [MAX_W-1:0] crc_step(input logic [MAX_W-1:0] crc,
                                                 input logic             d,
                                                 input logic [MAX_W-1:0] poly,
                                                 input int unsigned      w);
    logic [MAX_W-1:0] top;
    logic [MAX_W-1:0] nxt;
    logic [MAX_W-1:0] mask;
    logic             fb;
    top  = crc >> (w - 1);
    fb   = top[0] ^ d;
    nxt  = crc << 1;
    if (fb) nxt = nxt ^ poly;
    mask = {MAX_W{1'b1}} >> (MAX_W - w);
    return nxt & mask;
  endfunction

  // Reverse the low w bits of v; bits above w come back zero.
  function automatic logic [MAX_W-1:0] bitrev(input logic [MAX_W-1:0] v,
                                               input int unsigned      w);
    logic [MAX_W-1:0] r;
    logic [MAX_W-1:0] b;
    r = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        b = (v >> i) & {{(MAX_W-1){1'b0}}, 1'b1};
        r = r | (b << (w - 1 - i));
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// Combinational DW-bit CRC update: the serial LFSR unrolled once per data bit.
module crc_lfsr_step
  import crc_pkg::*;
#(
  parameter int unsigned      DW         = 16,
  parameter int unsigned      CRC_W      = 32,
  parameter logic [CRC_W-1:0] POLY       = 32'h04C11DB7,
  parameter bit               REFLECT_IN = 1'b1
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic [DW-1:0]    data,
  output logic [CRC_W-1:0] crc_out
);

  logic [CRC_W-1:0] acc;
  logic [DW-1:0]    ord;

  // ord is arranged so that the bit entering the LFSR first is always at the MSB.
  always_comb begin
    acc = crc_in;
    ord = REFLECT_IN ? DW'(bitrev(MAX_W'(data), DW)) : data;
    for (int i = 0; i < DW; i++) begin
      acc = CRC_W'(crc_step(MAX_W'(acc), ord[DW-1], MAX_W'(POLY), CRC_W));
      ord = ord << 1;
    end
    crc_out = acc;
  end

endmodule

// File: rtl/crc_stream_framer.sv
// Streaming CRC framer: GEN appends CRC words to each frame, CHK verifies the residue.
// state  | meaning
// DATA   | passing frame words through, folding each into crc_reg
// APPEND | emitting the N CRC words of a GEN frame, MS word first
module crc_stream_framer
  import crc_pkg::*;
#(
  parameter int unsigned      DW          = 16,
  parameter int unsigned      CRC_W       = 32,
  parameter logic [CRC_W-1:0] POLY        = 32'h04C11DB7,
  parameter logic [CRC_W-1:0] INIT        = '1,
  parameter logic [CRC_W-1:0] XOR_OUT     = '1,
  parameter bit               REFLECT_IN  = 1'b1,
  parameter bit               REFLECT_OUT = 1'b1,
  parameter logic [CRC_W-1:0] RESIDUE     = 32'hC704DD7B
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             mode,
  input  logic [DW-1:0]    s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [DW-1:0]    m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic             crc_done,
  output logic             crc_err,
  output logic [CRC_W-1:0] crc_value
);

  localparam int unsigned N  = CRC_W / DW;
  localparam int unsigned KW = $clog2(N + 1);

  if ((CRC_W % DW) != 0) begin : g_bad_width
    $error("crc_stream_framer: CRC_W must be a multiple of DW");
  end
  if (CRC_W > MAX_W) begin : g_too_wide
    $error("crc_stream_framer: CRC_W exceeds crc_pkg::MAX_W");
  end

  state_t           state, state_n;
  logic [KW-1:0]    k, k_n;
  logic [CRC_W-1:0] crc_reg, crc_n, crc_next, value_n;
  logic [DW-1:0]    data_n, word_raw, word_out;
  logic [CRC_W-1:0] crc_x, crc_sh;
  logic             valid_n, last_n, done_n, err_n;
  logic             mode_q, mode_n, first_q, first_n;
  logic             out_free, accept, cur_mode, last_crc;

  crc_lfsr_step #(
    .DW         (DW),
    .CRC_W      (CRC_W),
    .POLY       (POLY),
    .REFLECT_IN (REFLECT_IN)
  ) u_step (
    .crc_in  (crc_reg),
    .data    (s_data),
    .crc_out (crc_next)
  );

  assign out_free = ~m_valid | m_ready;
  assign s_ready  = (state == DATA) & out_free;
  assign accept   = s_valid & s_ready;
  // mode is only honoured on the first word; later words reuse the latched value.
  assign cur_mode = first_q ? mode : mode_q;

  assign crc_x    = crc_reg ^ XOR_OUT;
  assign crc_sh   = crc_x >> (CRC_W - DW - DW * 32'(k));
  assign word_raw = crc_sh[DW-1:0];
  assign word_out = REFLECT_OUT ? DW'(bitrev(MAX_W'(word_raw), DW)) : word_raw;
  assign last_crc = (k == KW'(N - 1));

  always_comb begin
    state_n = state;
    k_n     = k;
    crc_n   = crc_reg;
    data_n  = m_data;
    valid_n = m_valid;
    last_n  = m_last;
    done_n  = 1'b0;
    err_n   = 1'b0;
    value_n = crc_value;
    mode_n  = mode_q;
    first_n = first_q;

    if (m_valid && m_ready) begin
      valid_n = 1'b0;
      last_n  = 1'b0;
    end

    case (state)
      DATA: begin
        if (accept) begin
          data_n  = s_data;
          valid_n = 1'b1;
          last_n  = 1'b0;
          crc_n   = crc_next;
          mode_n  = cur_mode;
          first_n = 1'b0;
          if (s_last) begin
            first_n = 1'b1;
            if (cur_mode) begin
              last_n  = 1'b1;
              done_n  = 1'b1;
              err_n   = (crc_next != RESIDUE);
              value_n = crc_next;
              crc_n   = INIT;
            end else begin
              state_n = APPEND;
              k_n     = '0;
            end
          end
        end
      end
      APPEND: begin
        if (out_free) begin
          data_n  = word_out;
          valid_n = 1'b1;
          last_n  = last_crc;
          k_n     = k + KW'(1);
          if (last_crc) begin
            done_n  = 1'b1;
            value_n = crc_reg;
            crc_n   = INIT;
            state_n = DATA;
          end
        end
      end
      default: state_n = DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || init) begin
      state     <= DATA;
      k         <= '0;
      crc_reg   <= INIT;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      crc_done  <= 1'b0;
      crc_err   <= 1'b0;
      crc_value <= INIT;
      mode_q    <= 1'b0;
      first_q   <= 1'b1;
    end else begin
      state     <= state_n;
      k         <= k_n;
      crc_reg   <= crc_n;
      m_data    <= data_n;
      m_valid   <= valid_n;
      m_last    <= last_n;
      crc_done  <= done_n;
      crc_err   <= err_n;
      crc_value <= value_n;
      mode_q    <= mode_n;
      first_q   <= first_n;
    end
  end

endmodule

// File: tb/tb_crc_stream_framer.sv
// Bench for crc_stream_framer: CRC-32 byte instance against a reflected-table-free reference,
// plus two CRC-16 instances for the classic check values.
module tb_crc_stream_framer;

  typedef logic [7:0] bytes_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1, init_a = 1'b0, init_bc = 1'b0, mode = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0, s_valid_a = 1'b0, s_valid_b = 1'b0;
  logic       m_ready = 1'b0, m_ready_b = 1'b1;

  logic        s_ready_a, m_valid_a, m_last_a, crc_done_a, crc_err_a;
  logic [7:0]  m_data_a;
  logic [31:0] crc_value_a;
  logic        s_ready_b, m_valid_b, m_last_b, crc_done_b, crc_err_b;
  logic [7:0]  m_data_b;
  logic [15:0] crc_value_b;
  logic        s_ready_c, m_valid_c, m_last_c, crc_done_c, crc_err_c;
  logic [7:0]  m_data_c;
  logic [15:0] crc_value_c;

  crc_stream_framer #(.DW(8)) u_a (
    .clk(clk), .reset(reset), .init(init_a), .mode(mode),
    .s_data(s_data), .s_valid(s_valid_a), .s_last(s_last), .s_ready(s_ready_a),
    .m_data(m_data_a), .m_valid(m_valid_a), .m_last(m_last_a), .m_ready(m_ready),
    .crc_done(crc_done_a), .crc_err(crc_err_a), .crc_value(crc_value_a));

  crc_stream_framer #(.DW(8), .CRC_W(16), .POLY(16'h1021), .INIT(16'h0000), .XOR_OUT(16'h0000),
                      .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0), .RESIDUE(16'h0000)) u_b (
    .clk(clk), .reset(reset), .init(init_bc), .mode(mode),
    .s_data(s_data), .s_valid(s_valid_b), .s_last(s_last), .s_ready(s_ready_b),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_last(m_last_b), .m_ready(m_ready_b),
    .crc_done(crc_done_b), .crc_err(crc_err_b), .crc_value(crc_value_b));

  crc_stream_framer #(.DW(8), .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000),
                      .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0), .RESIDUE(16'h0000)) u_c (
    .clk(clk), .reset(reset), .init(init_bc), .mode(mode),
    .s_data(s_data), .s_valid(s_valid_b), .s_last(s_last), .s_ready(s_ready_c),
    .m_data(m_data_c), .m_valid(m_valid_c), .m_last(m_last_c), .m_ready(m_ready_b),
    .crc_done(crc_done_c), .crc_err(crc_err_c), .crc_value(crc_value_c));

  int n_cmp = 0, n_err = 0;
  int rdy_pct = 100, gap_pct = 0;
  logic mon_en = 1'b0, stalled = 1'b0, last_err = 1'b0;
  logic [8:0]  hold = '0;
  logic [31:0] tail = '0;
  logic [8:0]  exp_q[$];
  logic [32:0] done_q[$];
  logic [8:0]  cap_b[$], cap_c[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Standard reflected CRC-32 (right-shift form), as published for the check value.
  function automatic logic [31:0] crc32_ref(input bytes_t q);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    r = {<<{x}};
    return r;
  endfunction

  // Expected wire traffic: GEN appends the CRC LS byte first; the register is its reverse, un-XORed.
  task automatic expect_frame(input bytes_t q, input logic md);
    logic [31:0] c;
    c = crc32_ref(q);
    if (!md) begin
      foreach (q[i]) exp_q.push_back({1'b0, q[i]});
      for (int j = 0; j < 4; j++) exp_q.push_back({(j == 3), c[8*j +: 8]});
      done_q.push_back({1'b0, rev32(~c)});
    end else begin
      foreach (q[i]) exp_q.push_back({(i == q.size() - 1), q[i]});
      done_q.push_back({(c != 32'h2144DF1C), rev32(~c)});
    end
  endtask

  // Called at negedge+1; returns at negedge+1 after the last word is accepted.
  task automatic send(input bytes_t q, input logic md, input logic sel);
    int budget;
    foreach (q[i]) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        s_valid_a = 1'b0; s_valid_b = 1'b0;
        mode = $urandom_range(0, 1);
        @(negedge clk); #1;
      end
      if (sel) s_valid_b = 1'b1; else s_valid_a = 1'b1;
      s_data = q[i];
      s_last = (i == q.size() - 1);
      mode   = (i == 0) ? md : 1'($urandom_range(0, 1));
      budget = 0;
      while (!(sel ? s_ready_b : s_ready_a) && budget < 300) begin
        @(negedge clk); #1; budget++;
      end
      if (budget >= 300) chk("s_ready_timeout", sel ? s_ready_b : s_ready_a, 1);
      @(negedge clk); #1;
    end
    s_valid_a = 1'b0; s_valid_b = 1'b0; s_last = 1'b0;
  endtask

  task automatic run_frame(input bytes_t q, input logic md);
    expect_frame(q, md);
    send(q, md, 1'b0);
  endtask

  task automatic drain(input string tag, input int budget);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0 || m_valid_a) && t < budget) begin
      @(negedge clk); #1; t++;
    end
    chk(tag, exp_q.size() + done_q.size(), 0);
  endtask

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (stalled) chk("stall_hold", {m_last_a, m_data_a}, hold);
      m_ready = ($urandom_range(0, 99) < rdy_pct);
      if (m_valid_a && m_ready) begin
        chk("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("out_word", {m_last_a, m_data_a}, exp_q.pop_front());
        tail = {tail[23:0], m_data_a};
        stalled = 1'b0;
      end else begin
        stalled = m_valid_a;
        hold = {m_last_a, m_data_a};
      end
      if (crc_done_a) begin
        chk("done_expected", done_q.size() != 0, 1);
        if (done_q.size() != 0) chk("done_err_value", {crc_err_a, crc_value_a}, done_q.pop_front());
        last_err = crc_err_a;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_valid_b && m_ready_b) cap_b.push_back({m_last_b, m_data_b});
    if (m_valid_c && m_ready_b) cap_c.push_back({m_last_c, m_data_c});
  end

  initial begin
    bytes_t s, sp, sf, q, q2;
    logic [31:0] c;
    s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", m_valid_a, 0);
    chk("rst_m_last", m_last_a, 0);
    chk("rst_crc_done", crc_done_a, 0);
    chk("rst_crc_err", crc_err_a, 0);
    chk("rst_crc_value", crc_value_a, 32'hFFFFFFFF);
    chk("rst_crc_value_c", crc_value_c, 16'hFFFF);
    reset = 1'b0;
    #1;
    chk("rst_s_ready", s_ready_a, 1);

    // CRC-16/XMODEM and CRC-16/CCITT-FALSE over "123456789"
    send(s, 1'b0, 1'b1);
    for (int t = 0; t < 100 && cap_c.size() < 11; t++) begin @(negedge clk); #1; end
    chk("t1_count", cap_b.size(), 11);
    chk("t1_data8", cap_b[8], {1'b0, 8'h39});
    chk("t1_crc_hi", cap_b[9], {1'b0, 8'h31});
    chk("t1_crc_lo", cap_b[10], {1'b1, 8'hC3});
    chk("t1_value", crc_value_b, 16'h31C3);
    chk("t2_crc_hi", cap_c[9], {1'b0, 8'h29});
    chk("t2_crc_lo", cap_c[10], {1'b1, 8'hB1});
    chk("t2_value", crc_value_c, 16'h29B1);

    // CRC-32 check value, then CHK of the framed stream, good and corrupted
    mon_en = 1'b1; rdy_pct = 100; gap_pct = 0;
    run_frame(s, 1'b0);
    drain("t3_drain", 200);
    chk("t3_check_value", {tail[7:0], tail[15:8], tail[23:16], tail[31:24]}, 32'hCBF43926);
    sp = s;
    sp.push_back(8'h26); sp.push_back(8'h39); sp.push_back(8'hF4); sp.push_back(8'hCB);
    run_frame(sp, 1'b1);
    drain("t4_drain", 200);
    chk("t4_good_err", last_err, 0);
    sf = sp;
    sf[3] = sf[3] ^ 8'h04;
    run_frame(sf, 1'b1);
    drain("t4b_drain", 200);
    chk("t4_flip_err", last_err, 1);

    // init while APPEND has already emitted CRC word 0 (k=1)
    mon_en = 1'b0; m_ready = 1'b1;
    q = '{8'hA5};
    c = crc32_ref(q);
    s_valid_a = 1'b1; s_data = 8'hA5; s_last = 1'b1; mode = 1'b0;
    @(negedge clk); #1;
    s_valid_a = 1'b0; s_last = 1'b0;
    @(negedge clk);
    chk("t6_k1_word", {m_valid_a, m_last_a, m_data_a}, {2'b10, c[7:0]});
    init_a = 1'b1;
    @(negedge clk);
    chk("t6_m_valid", m_valid_a, 0);
    chk("t6_crc_value", crc_value_a, 32'hFFFFFFFF);
    chk("t6_no_done", crc_done_a, 0);
    init_a = 1'b0;
    for (int t = 0; t < 5; t++) begin @(negedge clk); chk("t6_quiet", {m_valid_a, crc_done_a}, 0); end
    #1;
    stalled = 1'b0; mon_en = 1'b1;
    q2 = '{8'h10, 8'h20, 8'h30};
    run_frame(q2, 1'b0);
    drain("t6_next_drain", 200);

    // randomized traffic with back-pressure and source gaps
    rdy_pct = 50; gap_pct = 30;
    for (int f = 0; f < 1000; f++) begin
      bytes_t r;
      logic md;
      int len;
      r = {};
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) r.push_back(8'($urandom));
      md = 1'($urandom_range(0, 1));
      if (md && $urandom_range(0, 1)) begin
        c = crc32_ref(r);
        for (int j = 0; j < 4; j++) r.push_back(c[8*j +: 8]);
      end
      run_frame(r, md);
    end
    drain("t5_drain", 3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
